proc_control_unit: RTL and testbench
====================================

Name: proc_control_unit

Overview:
- Multi-cycle control sequencer for the general-purpose processor datapath.
- Latches a 12-bit instruction on Run and steps a T-state machine (IDLE, T1..T3).
- Drives the one-hot register write/read selects, produced through 4-to-16 decode of the instruction register fields, plus the A/G/DIN bus controls and the ALU opcode.
- Sits between the instruction source and the register file / shared bus / ALU.

Parameters:
- SEL_W, 4, register-select field width; register count = 2**SEL_W (16). Only 4 is required to be supported.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  start request; sampled only in IDLE.
- FunIn  in  12  instruction {op[11:8], rx[7:4], ry[3:0]}.
- Rin  out  16  one-hot register write enable.
- Rout  out  16  one-hot register bus-drive select.
- DINout  out  1  external data drives bus.
- Ain  out  1  load ALU A register from bus.
- Gin  out  1  load ALU result register G.
- Gout  out  1  G drives bus.
- AluOp  out  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  high in the final step of an instruction.
- Illegal  out  1  high with Done when op is 8..15.
- InstrCount  out  CNT_W  count of completed instructions.

Behaviour:
- Registers:
  - state: IDLE, T1, T2, T3.
  - IR: 12 bits.
  - InstrCount.
- Reset, dominant over all other inputs:
  - state=IDLE, IR=0, InstrCount=0.
  - All control outputs are 0 in the cycle following the reset edge. Busy, Done and Illegal are 0.
  - Reset mid-instruction aborts it: no further Rin pulse, and no count increment.
- Control outputs are combinational from state and IR only. No combinational path from Run or FunIn to any output.
- IDLE:
  - All controls 0.
  - Run=1 at an edge: IR<=FunIn, state<=T1.
  - Run=0: stay in IDLE.
- Run is ignored while Busy. FunIn changes while Busy have no effect.
- rx and ry index registers through a 4-to-16 one-hot decode, with the enable equal to the step qualifier. Rin and Rout each carry at most one bit set; both are all-zero when not in use.
- Per-op step actions (all unlisted outputs 0):
  - op 0 LD: T1: DINout=1, Rin[rx]=1, Done=1.
  - op 1 MV: T1: Rout[ry]=1, Rin[rx]=1, Done=1. rx==ry is legal; the register is rewritten with itself.
  - op 2..6 ADD/SUB/AND/OR/XOR:
    - T1: Rout[rx]=1, Ain=1.
    - T2: Rout[ry]=1, Gin=1, AluOp = op-2.
    - T3: Gout=1, Rin[rx]=1, Done=1.
  - op 7 NOT:
    - T1: Rout[rx]=1, Ain=1.
    - T2: Gin=1, AluOp=101, Rout=0 (bus idle).
    - T3: Gout=1, Rin[rx]=1, Done=1.
  - op 8..15: T1: Done=1, Illegal=1, no enables.
- AluOp is 000 in every cycle except T2 of ops 2..7.
- Transitions:
  - From any state where Done=1: next state is IDLE.
  - T1 to T2, and T2 to T3, for ALU ops.
- Latency, Run edge to Done cycle:
  - LD/MV/illegal: Done in the first cycle after the Run edge (2 cycles per instruction including IDLE).
  - ALU ops: Done in the third cycle after the Run edge (4 cycles per instruction).
- Back-to-back: Run held high re-issues immediately after the IDLE cycle. The Run sample in the Done cycle is ignored.
- InstrCount:
  - Increments by 1 at the edge ending every Done cycle, including illegal ops.
  - Wraps from 2**CNT_W-1 to 0.
  - Reset wins over increment.

Test Plan:
- Reset then idle:
  - Hold Reset 2 cycles with Run=1 and FunIn=0x123 -> all outputs 0 and InstrCount=0 during reset.
  - Release Reset -> one IDLE cycle, then the instruction starts.
- LD and MV:
  - Run with FunIn=0x050 -> next cycle DINout=1, Rin=0x0020, Done=1.
  - Then FunIn=0x1A3 -> Rout=0x0008, Rin=0x0400, Done=1.
  - InstrCount=2 afterwards.
- ADD r2,r9 (FunIn=0x229):
  - T1: Rout=0x0004, Ain=1.
  - T2: Rout=0x0200, Gin=1, AluOp=000.
  - T3: Gout=1, Rin=0x0004, Done=1.
  - Busy is high for exactly 3 cycles.
- NOT r15 (0x7F0) and XOR (0x61E):
  - NOT: T2 has Rout=0, AluOp=101.
  - XOR: T2 has AluOp=100, Rout=0x4000.
  - Changing FunIn mid-instruction has no effect on either.
- Illegal op 0xC55:
  - Next cycle Done=1, Illegal=1, Rin=Rout=0.
  - InstrCount increments.
- Reset mid-op and wrap:
  - Assert Reset in T2 of a SUB -> no Rin pulse, and IDLE follows.
  - Preload by running 65535 instructions (or force the count) -> the next Done wraps InstrCount to 0.

Source files
------------

// File: rtl/proc_control_unit.sv
// proc_control_unit: multi-cycle control sequencer for the processor datapath.
// Latches a 12-bit instruction {op, rx, ry} on Run and steps IDLE -> T1..T3,
// producing one-hot register selects, bus/ALU controls and a retired-instruction
// counter. Control outputs are decoded from the state and IR only.
//
// Ports:
//   Clock, Reset     : system clock, synchronous active-high reset
//   Run, FunIn       : start request and instruction (sampled in IDLE only)
//   Rin, Rout        : one-hot register write enable / bus-drive select
//   DINout, Ain, Gin, Gout : shared-bus and ALU register controls
//   AluOp            : ALU function (valid in T2 of ALU ops, else 000)
//   Busy, Done, Illegal : status
//   InstrCount       : completed-instruction count (wraps)
module proc_control_unit #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic [11:0]           FunIn,
  output logic [2**SEL_W-1:0]   Rin,
  output logic [2**SEL_W-1:0]   Rout,
  output logic                  DINout,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  Gout,
  output logic [2:0]            AluOp,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Illegal,
  output logic [CNT_W-1:0]      InstrCount
);

  localparam int unsigned NREG = 2**SEL_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [11:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]         op;
  logic [SEL_W-1:0]   rx, ry;
  logic               is_alu;
  logic               rin_en, rout_rx_en, rout_ry_en;

  assign op     = ir_q[11:8];
  assign rx     = ir_q[2*SEL_W-1:SEL_W];
  assign ry     = ir_q[SEL_W-1:0];
  assign is_alu = (op >= 4'd2) && (op <= 4'd7);

  // Enabled one-hot decoder for a register index.
  function automatic logic [NREG-1:0] dec(input logic en, input logic [SEL_W-1:0] idx);
    dec = en ? (NREG'(1) << idx) : '0;
  endfunction

  // State, instruction and counter registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and step controls.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    rin_en     = 1'b0;
    rout_rx_en = 1'b0;
    rout_ry_en = 1'b0;
    DINout     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    AluOp      = 3'b000;
    Done       = 1'b0;
    Illegal    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Run) begin
          ir_d    = FunIn;
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (op[3]) begin
          Done    = 1'b1;
          Illegal = 1'b1;
          state_d = S_IDLE;
        end else if (op == 4'd0) begin
          DINout  = 1'b1;
          rin_en  = 1'b1;
          Done    = 1'b1;
          state_d = S_IDLE;
        end else if (op == 4'd1) begin
          rout_ry_en = 1'b1;
          rin_en     = 1'b1;
          Done       = 1'b1;
          state_d    = S_IDLE;
        end else begin
          rout_rx_en = 1'b1;
          Ain        = 1'b1;
          state_d    = S_T2;
        end
      end
      S_T2: begin
        Gin = 1'b1;
        // NOT leaves the bus idle; the binary ops map op 2..6 onto AluOp 0..4.
        if (op == 4'd7) begin
          AluOp = 3'b101;
        end else begin
          rout_ry_en = 1'b1;
          AluOp      = 3'(op - 4'd2);
        end
        state_d = is_alu ? S_T3 : S_IDLE;
      end
      S_T3: begin
        Gout    = 1'b1;
        rin_en  = 1'b1;
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = cnt_q + CNT_W'(Done);
  end

  assign Rin        = dec(rin_en, rx);
  assign Rout       = dec(rout_rx_en, rx) | dec(rout_ry_en, ry);
  assign Busy       = (state_q != S_IDLE);
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit: directed and randomized
// instructions compared cycle by cycle against a table-driven step model.
// A second instance with a 4-bit counter exercises counter wrap-around.
module tb_proc_control_unit;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        dinout;
    logic        ain;
    logic        gin;
    logic        gout;
    logic [2:0]  aluop;
    logic        done;
    logic        illegal;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [11:0] fun_in;

  logic [15:0] rin, rout, rin_s, rout_s;
  logic        dinout, ain, gin, gout, busy, done, illegal;
  logic        dinout_s, ain_s, gin_s, gout_s, busy_s, done_s, illegal_s;
  logic [2:0]  aluop, aluop_s;
  logic [15:0] instr_count;
  logic [3:0]  instr_count_s;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  proc_control_unit dut (
    .Clock(clk), .Reset(rst), .Run(run), .FunIn(fun_in),
    .Rin(rin), .Rout(rout), .DINout(dinout), .Ain(ain), .Gin(gin), .Gout(gout),
    .AluOp(aluop), .Busy(busy), .Done(done), .Illegal(illegal),
    .InstrCount(instr_count)
  );

  proc_control_unit #(.SEL_W(4), .CNT_W(4)) dut_small (
    .Clock(clk), .Reset(rst), .Run(run), .FunIn(fun_in),
    .Rin(rin_s), .Rout(rout_s), .DINout(dinout_s), .Ain(ain_s), .Gin(gin_s),
    .Gout(gout_s), .AluOp(aluop_s), .Busy(busy_s), .Done(done_s),
    .Illegal(illegal_s), .InstrCount(instr_count_s)
  );

  function automatic ctl_t get_obs();
    ctl_t o;
    o.rin = rin; o.rout = rout; o.dinout = dinout; o.ain = ain; o.gin = gin;
    o.gout = gout; o.aluop = aluop; o.done = done; o.illegal = illegal;
    return o;
  endfunction

  // Number of T-steps an instruction occupies.
  function automatic int nsteps(input logic [11:0] instr);
    int op;
    op = int'(instr[11:8]);
    return (op >= 2 && op <= 7) ? 3 : 1;
  endfunction

  // Expected controls in step k (0 = T1) of an instruction.
  function automatic ctl_t model(input logic [11:0] instr, input int k);
    ctl_t c;
    int op, rx, ry;
    op = int'(instr[11:8]);
    rx = int'(instr[7:4]);
    ry = int'(instr[3:0]);
    c = '0;
    if (op >= 8) begin
      if (k == 0) begin c.done = 1'b1; c.illegal = 1'b1; end
    end else if (op == 0) begin
      c.dinout = 1'b1; c.rin = 16'(1 << rx); c.done = 1'b1;
    end else if (op == 1) begin
      c.rout = 16'(1 << ry); c.rin = 16'(1 << rx); c.done = 1'b1;
    end else begin
      case (k)
        0: begin c.rout = 16'(1 << rx); c.ain = 1'b1; end
        1: begin
          c.gin   = 1'b1;
          c.aluop = (op == 7) ? 3'd5 : 3'(op - 2);
          c.rout  = (op == 7) ? 16'd0 : 16'(1 << ry);
        end
        default: begin c.gout = 1'b1; c.rin = 16'(1 << rx); c.done = 1'b1; end
      endcase
    end
    return c;
  endfunction

  // Issue one instruction from an IDLE negedge; returns at the following IDLE negedge.
  task automatic issue(input logic [11:0] instr, input bit hold_run);
    ctl_t exp_c, obs;
    int n;
    obs = get_obs();
    checks++;
    if (obs !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_before %h: obs=%h busy=%b required=0", instr, obs, busy);
    end
    run    = 1'b1;
    fun_in = instr;
    n = nsteps(instr);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp_c = model(instr, k);
      obs   = get_obs();
      checks++;
      if (obs !== exp_c) begin
        errors++;
        $display("FAIL step %h T%0d: obs=%h required=%h", instr, k + 1, obs, exp_c);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy %h T%0d: obs=%b required=1", instr, k + 1, busy);
      end
      if (!hold_run) run = 1'b0;
      fun_in = 12'($urandom);
    end
    @(negedge clk);
    model_cnt++;
    checks++;
    if (instr_count !== 16'(model_cnt) || instr_count_s !== 4'(model_cnt)) begin
      errors++;
      $display("FAIL count %h: obs=%0d/%0d required=%0d/%0d", instr, instr_count,
               instr_count_s, 16'(model_cnt), 4'(model_cnt));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; fun_in = 12'h123;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (get_obs() !== '0 || busy !== 1'b0 || instr_count !== 16'd0 || instr_count_s !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold: obs=%h busy=%b cnt=%0d required all 0",
                 get_obs(), busy, instr_count);
      end
    end
    rst = 1'b0;
    model_cnt = 0;
    // Cycle of release is IDLE; Run is then sampled and MV r2,r3 runs.
    issue(12'h123, 1'b0);
  endtask

  task automatic test_ld_mv();
    do_reset();
    issue(12'h050, 1'b0);
    issue(12'h1A3, 1'b0);
    checks++;
    if (instr_count !== 16'd2) begin
      errors++;
      $display("FAIL ld_mv_count: obs=%0d required=2", instr_count);
    end
    issue(12'h155, 1'b0);
  endtask

  task automatic test_alu();
    issue(12'h229, 1'b0);
    issue(12'h7F0, 1'b0);
    issue(12'h61E, 1'b0);
    issue(12'h3C1, 1'b0);
    issue(12'h4D2, 1'b0);
    issue(12'h5E3, 1'b0);
  endtask

  task automatic test_illegal();
    issue(12'hC55, 1'b0);
    issue(12'h8FF, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [11:0] seq [5];
    seq = '{12'h229, 12'h050, 12'hC55, 12'h7F0, 12'h1A3};
    foreach (seq[i]) issue(seq[i], 1'b1);
    run = 1'b0;
  endtask

  task automatic test_reset_midop();
    ctl_t obs;
    run = 1'b1; fun_in = 12'h3A5;
    @(negedge clk);
    run = 1'b0; fun_in = 12'h000;
    checks++;
    if (get_obs() !== model(12'h3A5, 0)) begin
      errors++;
      $display("FAIL midop_t1: obs=%h required=%h", get_obs(), model(12'h3A5, 0));
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    obs = get_obs();
    checks++;
    if (obs !== '0 || busy !== 1'b0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL midop_reset: obs=%h busy=%b cnt=%0d required 0", obs, busy, instr_count);
    end
    @(negedge clk);
    checks++;
    if (rin !== 16'd0 || busy !== 1'b0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL midop_after: rin=%h busy=%b cnt=%0d required 0", rin, busy, instr_count);
    end
  endtask

  task automatic test_random_wrap();
    for (int i = 0; i < 40; i++) begin
      issue(12'($urandom), 1'($urandom_range(0, 1)));
      run = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; fun_in = '0;
    test_reset();
    test_ld_mv();
    test_alu();
    test_illegal();
    test_back_to_back();
    test_reset_midop();
    test_random_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
